// File: rtl/bird_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : bird_scheduler
// Brief   : Duck Hunt round/bird-release scheduler: random launch delay and
//           start column, flight timeout, per-round hit and speed bookkeeping.
// Rev     : 1.0  initial release
//==============================================================================
module bird_scheduler #(
    parameter int FRAME_DELAY     = 60,
    parameter int BIRDS_PER_ROUND = 10,
    parameter int MAX_LEVEL       = 7,
    parameter int TIMEOUT_FRAMES  = 300
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       bird_shot,
    input  logic       flew_away,
    output logic       release_bird,
    output logic [9:0] start_x,
    output logic       dir_right,
    output logic [2:0] speed,
    output logic [3:0] round_num,
    output logic [3:0] birds_left,
    output logic [3:0] round_hits,
    output logic       round_done,
    output logic       force_escape,
    output logic       busy
);

    localparam logic [7:0]  c_frame_delay = 8'(FRAME_DELAY);
    localparam logic [3:0]  c_birds       = 4'(BIRDS_PER_ROUND);
    localparam logic [2:0]  c_max_level   = 3'(MAX_LEVEL);
    localparam logic [9:0]  c_timeout     = 10'(TIMEOUT_FRAMES);
    localparam logic [15:0] c_lfsr_seed   = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT      = 3'd1,
        S_LAUNCH    = 3'd2,
        S_FLY       = 3'd3,
        S_RESOLVE   = 3'd4,
        S_ROUND_END = 3'd5
    } state_t;

    state_t      r_state, w_next_state;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [7:0]  r_delay_cnt;
    logic [9:0]  r_timeout_cnt;
    logic [3:0]  r_hit_cnt;
    logic        r_was_hit;

    logic        r_release, r_dir, r_round_done, r_force_escape, r_busy;
    logic [9:0]  r_start_x;
    logic [2:0]  r_speed;
    logic [3:0]  r_round_num, r_birds_left, r_round_hits;

    logic w_round_start, w_dec_delay, w_dec_timeout, w_fly_done, w_fly_hit;
    logic w_timeout, w_resolve, w_round_clear, w_load_delay, w_launch;

    // Taps 16,15,13,4 of x^16+x^15+x^13+x^4+1
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_round_start = 1'b0;
        w_dec_delay   = 1'b0;
        w_dec_timeout = 1'b0;
        w_fly_done    = 1'b0;
        w_fly_hit     = 1'b0;
        w_timeout     = 1'b0;
        w_resolve     = 1'b0;
        w_round_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state  = S_WAIT;
                    w_round_start = 1'b1;
                end
            end
            S_WAIT: begin
                if (!enable)                  w_next_state = S_IDLE;
                else if (r_delay_cnt == 8'd0) w_next_state = S_LAUNCH;
                else if (frame_tick)          w_dec_delay  = 1'b1;
            end
            S_LAUNCH: begin
                w_next_state = enable ? S_FLY : S_IDLE;
            end
            S_FLY: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (bird_shot) begin
                    w_next_state = S_RESOLVE;
                    w_fly_done   = 1'b1;
                    w_fly_hit    = 1'b1;
                end else if (flew_away) begin
                    w_next_state = S_RESOLVE;
                    w_fly_done   = 1'b1;
                end else if (frame_tick) begin
                    if (r_timeout_cnt == 10'd1) begin
                        w_next_state = S_RESOLVE;
                        w_fly_done   = 1'b1;
                        w_timeout    = 1'b1;
                    end else begin
                        w_dec_timeout = 1'b1;
                    end
                end
            end
            S_RESOLVE: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_resolve    = 1'b1;
                    w_next_state = (r_birds_left <= 4'd1) ? S_ROUND_END : S_WAIT;
                end
            end
            S_ROUND_END: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_round_clear = 1'b1;
                    w_next_state  = S_WAIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_load_delay = (w_next_state == S_WAIT) && (r_state != S_WAIT);
    assign w_launch     = (w_next_state == S_LAUNCH);

    // Outputs are registered from the next-state decision so each pulse
    // lines up with the state it names (release_bird during LAUNCH, etc.).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr         <= c_lfsr_seed;
            r_delay_cnt    <= 8'd0;
            r_timeout_cnt  <= 10'd0;
            r_hit_cnt      <= 4'd0;
            r_was_hit      <= 1'b0;
            r_release      <= 1'b0;
            r_start_x      <= 10'd0;
            r_dir          <= 1'b0;
            r_speed        <= 3'd0;
            r_round_num    <= 4'd0;
            r_birds_left   <= 4'd0;
            r_round_hits   <= 4'd0;
            r_round_done   <= 1'b0;
            r_force_escape <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_lfsr         <= {r_lfsr[14:0], w_lfsr_fb};
            r_release      <= w_launch;
            r_round_done   <= (w_next_state == S_ROUND_END);
            r_force_escape <= w_timeout;
            r_busy         <= (w_next_state != S_IDLE);

            if (w_load_delay)
                r_delay_cnt <= c_frame_delay + {4'd0, r_lfsr[3:0]};
            else if (w_dec_delay)
                r_delay_cnt <= r_delay_cnt - 8'd1;

            if (w_launch) begin
                r_start_x     <= 10'd32 + {1'b0, r_lfsr[8:0]};
                r_dir         <= r_lfsr[9];
                r_timeout_cnt <= c_timeout;
            end else if (w_dec_timeout) begin
                r_timeout_cnt <= r_timeout_cnt - 10'd1;
            end

            if (w_fly_done)
                r_was_hit <= w_fly_hit;

            if (w_round_start) begin
                r_birds_left <= c_birds;
                r_hit_cnt    <= 4'd0;
                r_speed      <= 3'd0;
                r_round_num  <= 4'd0;
            end else if (w_resolve) begin
                r_birds_left <= r_birds_left - 4'd1;
                r_hit_cnt    <= r_hit_cnt + {3'd0, r_was_hit};
                // Round totals are published together with round_done
                if (w_next_state == S_ROUND_END) begin
                    r_round_hits <= r_hit_cnt + {3'd0, r_was_hit};
                    if (r_round_num != 4'd15)  r_round_num <= r_round_num + 4'd1;
                    if (r_speed < c_max_level) r_speed     <= r_speed + 3'd1;
                end
            end else if (w_round_clear) begin
                r_birds_left <= c_birds;
                r_hit_cnt    <= 4'd0;
            end
        end
    end

    assign release_bird = r_release;
    assign start_x      = r_start_x;
    assign dir_right    = r_dir;
    assign speed        = r_speed;
    assign round_num    = r_round_num;
    assign birds_left   = r_birds_left;
    assign round_hits   = r_round_hits;
    assign round_done   = r_round_done;
    assign force_escape = r_force_escape;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bird_scheduler.sv
`default_nettype none
//==============================================================================
// Module  : tb_bird_scheduler
// Brief   : Randomized self-checking bench for bird_scheduler with an
//           event-level reference model (LFSR history, tick counting).
// Rev     : 1.0  initial release
//==============================================================================
module tb_bird_scheduler;

    localparam int BPR = 3;
    localparam int FD  = 2;
    localparam int ML  = 7;
    localparam int TO  = 4;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, enable, bird_shot, flew_away;
    logic       release_bird, dir_right, round_done, force_escape, busy;
    logic [9:0] start_x;
    logic [2:0] speed;
    logic [3:0] round_num, birds_left, round_hits;

    bird_scheduler #(
        .FRAME_DELAY(FD), .BIRDS_PER_ROUND(BPR), .MAX_LEVEL(ML), .TIMEOUT_FRAMES(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
        .bird_shot(bird_shot), .flew_away(flew_away), .release_bird(release_bird),
        .start_x(start_x), .dir_right(dir_right), .speed(speed), .round_num(round_num),
        .birds_left(birds_left), .round_hits(round_hits), .round_done(round_done),
        .force_escape(force_escape), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    logic [15:0] hist [0:32767];

    // Reference model state
    int m_went, m_bl, m_hits, m_rn, m_sp, m_rh, m_rounds;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hD008)};
    endfunction

    function automatic logic [29:0] outs();
        return {release_bird, start_x, dir_right, speed, round_num, birds_left,
                round_hits, round_done, force_escape, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
        cyc++;
        bird_shot  = 1'b0;
        flew_away  = 1'b0;
        frame_tick = (cyc % 4 == 0);
    endtask

    task automatic sync_reset();
        Reset = 1'b1;
        advance();
        advance();
        Reset      = 1'b0;
        cyc        = 0;
        frame_tick = 1'b1;
    endtask

    // Launch cycle: two cycles after the WAIT-entry decision plus the frames
    // counted down (only ticks seen while WAIT still has a nonzero count).
    function automatic int pred_release(input int went);
        logic [15:0] v;
        int d, n, t;
        v = hist[went];
        d = FD + int'(v[3:0]);
        if (d == 0) return went + 2;
        n = 0;
        t = went;
        while (n < d) begin
            t++;
            if (t % 4 == 0) n++;
        end
        return t + 2;
    endfunction

    task automatic start_game();
        enable = 1'b1;
        m_went = cyc;
        m_bl   = BPR;
        m_hits = 0;
        m_rn   = 0;
        m_sp   = 0;
        advance();
        chk("start_birds_left", birds_left, BPR);
        chk("start_round_num", round_num, 0);
        chk("start_speed", speed, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_release(output bit ok);
        int r;
        logic [15:0] v;
        r  = pred_release(m_went);
        ok = 1'b0;
        while (release_bird !== 1'b1 && cyc < r + 8) advance();
        if (release_bird !== 1'b1) begin
            chk("release_seen", 0, 1);
            return;
        end
        ok = 1'b1;
        chk("release_cycle", cyc, r);
        v = hist[cyc - 1];
        chk("start_x", start_x, 32 + int'(v[8:0]));
        chk("dir_right", dir_right, v[9]);
        chk("start_x_range", (start_x >= 32 && start_x <= 543), 1);
    endtask

    // kind: 0 shot, 1 flew away, 2 shot+flew same cycle, 3 no response
    task automatic do_bird(input int kind, input int k);
        bit ok;
        int r, t, n;
        wait_release(ok);
        if (!ok) return;
        r = cyc;
        advance();
        chk("release_width", release_bird, 0);
        if (kind < 3) begin
            repeat (k - 1) advance();
            bird_shot = (kind == 0 || kind == 2);
            flew_away = (kind == 1 || kind == 2);
            t = cyc;
            advance();
            chk("no_escape", force_escape, 0);
        end else begin
            n = 0;
            t = r;
            while (n < TO) begin
                t++;
                if (t % 4 == 0) n++;
            end
            while (force_escape !== 1'b1 && cyc < t + 4) advance();
            chk("escape_cycle", cyc, t + 1);
            t = cyc - 1;
        end
        m_bl--;
        if (kind == 0 || kind == 2) m_hits++;
        advance();
        chk("birds_left", birds_left, m_bl);
        if (m_bl == 0) begin
            m_rn = (m_rn < 15) ? m_rn + 1 : 15;
            m_sp = (m_sp < ML) ? m_sp + 1 : ML;
            m_rh = m_hits;
            m_rounds++;
            chk("round_done", round_done, 1);
            chk("round_hits", round_hits, m_rh);
            chk("round_num", round_num, m_rn);
            chk("speed", speed, m_sp);
            m_went = cyc;
            advance();
            chk("round_done_width", round_done, 0);
            chk("birds_reload", birds_left, BPR);
            m_bl   = BPR;
            m_hits = 0;
        end else begin
            chk("no_round_done", round_done, 0);
            m_went = cyc - 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        hist[0] = 16'hACE1;
        for (int i = 1; i < 32768; i++) hist[i] = lfsr_step(hist[i - 1]);
        enable = 1'b0; bird_shot = 1'b0; flew_away = 1'b0; frame_tick = 1'b0;
        m_rounds = 0;

        // Reset state and idle hold
        sync_reset();
        chk("reset_outputs", {2'b0, outs()}, 0);
        repeat (100) begin
            advance();
            chk("idle_outputs", {2'b0, outs()}, 0);
        end

        // First round: shot, miss, shot
        start_game();
        do_bird(0, $urandom_range(1, 12));
        do_bird(1, $urandom_range(1, 12));
        do_bird(0, $urandom_range(1, 12));
        chk("round1_hits", m_rh, 2);

        // Timeout, simultaneous shot+flew, then random birds up to 20 rounds
        do_bird(3, 0);
        do_bird(2, $urandom_range(1, 12));
        while (m_rounds < 20) do_bird($urandom_range(0, 3), $urandom_range(1, 12));
        chk("speed_saturated", speed, ML);
        chk("round_num_saturated", round_num, 15);

        // Abort while in WAIT (first WAIT cycle, count still >= FD)
        enable = 1'b0;
        advance();
        chk("wait_abort_busy", busy, 0);
        chk("wait_abort_pulses", {release_bird, round_done, force_escape}, 0);
        repeat (10) begin
            advance();
            chk("idle_no_release", release_bird, 0);
        end
        chk("abort_hold_round_num", round_num, 15);
        start_game();

        // Abort mid-flight
        wait_release(ok);
        advance();
        advance();
        enable = 1'b0;
        advance();
        chk("fly_abort_busy", busy, 0);
        chk("fly_abort_pulses", {release_bird, round_done, force_escape}, 0);
        chk("fly_abort_birds_held", birds_left, BPR);
        repeat (5) advance();
        start_game();

        // Reset mid-flight
        wait_release(ok);
        advance();
        Reset = 1'b1;
        advance();
        chk("reset_mid_fly", {2'b0, outs()}, 0);
        Reset  = 1'b0;
        enable = 1'b0;
        advance();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
